// File: rtl/next_state_sequencer_pkg.sv
// Shared sequencing-mode encodings and well-known control-store addresses for the
// multicycle MIPS control unit (sequencer, control ROM, state encoder).
package next_state_sequencer_pkg;

   localparam int SEQ_STATE_W = 7;

   localparam logic [2:0] SEQ_DISPATCH = 3'b000;
   localparam logic [2:0] SEQ_INC      = 3'b001;
   localparam logic [2:0] SEQ_JUMP     = 3'b010;
   localparam logic [2:0] SEQ_BR       = 3'b011;
   localparam logic [2:0] SEQ_WAIT     = 3'b100;
   localparam logic [2:0] SEQ_BRN      = 3'b101;

   localparam int SEQ_RESET_STATE = 0;
   localparam int SEQ_FETCH_STATE = 1;
   localparam int SEQ_FAULT_STATE = 127;

endpackage

// File: rtl/next_state_sequencer_next_addr_mux.sv
// Combinational next-address selection: mode decode, wrapping incrementer and the
// memory-wait stall qualifier.
module next_addr_mux
   import next_state_sequencer_pkg::*;
#(
   parameter int STATE_W     = SEQ_STATE_W,
   parameter int FETCH_STATE = SEQ_FETCH_STATE
) (
   input  logic [2:0]         i_n,
   input  logic [STATE_W-1:0] i_state,
   input  logic [STATE_W-1:0] i_state_sel,
   input  logic [STATE_W-1:0] i_cr,
   input  logic               i_cond,
   input  logic               i_moc,
   output logic [STATE_W-1:0] o_next,
   output logic               o_stall
);

   localparam logic [STATE_W-1:0] FETCH_ADDR = FETCH_STATE[STATE_W-1:0];
   localparam logic [STATE_W-1:0] ONE        = {{(STATE_W-1){1'b0}}, 1'b1};

   logic [STATE_W-1:0] w_inc;

   // Incrementer wraps naturally at STATE_W bits.
   assign w_inc   = i_state + ONE;
   assign o_stall = (i_n == SEQ_WAIT) && !i_moc;

   always_comb begin
      o_next = FETCH_ADDR;
      case (i_n)
         SEQ_DISPATCH: o_next = i_state_sel;
         SEQ_INC:      o_next = w_inc;
         SEQ_JUMP:     o_next = i_cr;
         SEQ_BR:       o_next = i_cond ? i_cr : w_inc;
         SEQ_WAIT:     o_next = i_moc ? w_inc : i_state;
         SEQ_BRN:      o_next = i_cond ? w_inc : i_cr;
         default:      o_next = FETCH_ADDR;
      endcase
   end

endmodule

// File: rtl/next_state_sequencer.sv
// Microprogram sequencer: registers the next control-store address each cycle.
// Optional MOC wait timeout enabled by defining SEQ_MOC_TIMEOUT_EN.
module next_state_sequencer
   import next_state_sequencer_pkg::*;
#(
   parameter int STATE_W     = SEQ_STATE_W,
   parameter int RESET_STATE = SEQ_RESET_STATE,
   parameter int FETCH_STATE = SEQ_FETCH_STATE,
   parameter int FAULT_STATE = SEQ_FAULT_STATE,
   parameter int TIMEOUT     = 255
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [STATE_W-1:0] State_Sel,
   input  logic [2:0]         N,
   input  logic [STATE_W-1:0] CR,
   input  logic               Cond,
   input  logic               MOC,
   output logic [STATE_W-1:0] State,
   output logic               Stall,
   output logic               Timeout_Err
);

   localparam logic [STATE_W-1:0] RESET_ADDR = RESET_STATE[STATE_W-1:0];

   // Reject parameter sets that cannot be represented in hardware.
   if ((TIMEOUT < 1) || (TIMEOUT > 1023) ||
       (FAULT_STATE >= (1 << STATE_W)) || (FETCH_STATE >= (1 << STATE_W)) ||
       (RESET_STATE >= (1 << STATE_W))) begin : g_bad_params
      $error("next_state_sequencer: parameter out of range");
   end

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;
   logic               w_stall;

   next_addr_mux #(
      .STATE_W     (STATE_W),
      .FETCH_STATE (FETCH_STATE)
   ) u_next_addr_mux (
      .i_n         (N),
      .i_state     (r_state),
      .i_state_sel (State_Sel),
      .i_cr        (CR),
      .i_cond      (Cond),
      .i_moc       (MOC),
      .o_next      (w_next),
      .o_stall     (w_stall)
   );

   assign State = r_state;
   assign Stall = w_stall;

`ifdef SEQ_MOC_TIMEOUT_EN
   localparam logic [STATE_W-1:0] FAULT_ADDR = FAULT_STATE[STATE_W-1:0];
   localparam logic [9:0]         TIMEOUT_CNT = TIMEOUT[9:0];

   logic [9:0] r_wait_cnt;
   logic       r_timeout_err;
   logic [9:0] w_cnt_inc;
   logic       w_timeout;

   // Timeout fires on the edge that would bring the count up to TIMEOUT; a MOC
   // in that cycle drops Stall and therefore wins.
   assign w_cnt_inc = r_wait_cnt + 10'd1;
   assign w_timeout = w_stall && (w_cnt_inc == TIMEOUT_CNT);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state       <= RESET_ADDR;
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state    <= w_timeout ? FAULT_ADDR : w_next;
         r_wait_cnt <= (w_stall && !w_timeout) ? w_cnt_inc : 10'd0;
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign Timeout_Err = r_timeout_err;
`else
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= RESET_ADDR;
      end else begin
         r_state <= w_next;
      end
   end

   assign Timeout_Err = 1'b0;
`endif

endmodule

// File: tb/tb_next_state_sequencer.sv
// Bench for next_state_sequencer: directed test-plan steps followed by random
// traffic, all checked against an arithmetic model (SEQ_MOC_TIMEOUT_EN aware).
module tb_next_state_sequencer;

`ifdef SEQ_MOC_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [6:0] State_Sel = '0;
   logic [2:0] N = '0;
   logic [6:0] CR = '0;
   logic       Cond = 1'b0;
   logic       MOC = 1'b0;
   logic [6:0] State;
   logic       Stall;
   logic       Timeout_Err;

   int n_cmp = 0;
   int n_bad = 0;

   int m_state = 0;
   int m_cnt   = 0;
   int m_err   = 0;

   next_state_sequencer #(
      .STATE_W     (7),
      .RESET_STATE (0),
      .FETCH_STATE (1),
      .FAULT_STATE (127),
      .TIMEOUT     (TO)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .State_Sel   (State_Sel),
      .N           (N),
      .CR          (CR),
      .Cond        (Cond),
      .MOC         (MOC),
      .State       (State),
      .Stall       (Stall),
      .Timeout_Err (Timeout_Err)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, check Stall before the edge and State/flag after it.
   task automatic step(input bit rst, input int n, input int sel, input int cr,
                       input bit c, input bit m);
      int nx;
      int inc;
      bit stalled;
      Reset     = rst;
      N         = n[2:0];
      State_Sel = sel[6:0];
      CR        = cr[6:0];
      Cond      = c;
      MOC       = m;
      stalled   = (n == 4) && !m;
      #1;
      check("stall", {31'd0, Stall}, {31'd0, stalled});

      inc = (m_state + 1) % 128;
      case (n)
         0:       nx = sel;
         1:       nx = inc;
         2:       nx = cr;
         3:       nx = c ? cr : inc;
         4:       nx = m ? inc : m_state;
         5:       nx = c ? inc : cr;
         default: nx = 1;
      endcase
`ifdef SEQ_MOC_TIMEOUT_EN
      if (stalled) begin
         m_cnt++;
         if (m_cnt == TO) begin
            nx    = 127;
            m_err = 1;
            m_cnt = 0;
         end
      end else begin
         m_cnt = 0;
      end
`endif
      if (rst) begin
         nx    = 0;
         m_err = 0;
         m_cnt = 0;
      end
      m_state = nx;

      @(posedge Clk);
      #1;
      check("state", State, m_state);
      check("err", {31'd0, Timeout_Err}, m_err);
   endtask

   initial begin
      @(posedge Clk);
      #1;
      // Reset then dispatch
      step(1, 0, 13, 0, 0, 1);  check("rst_state", State, 0);
      step(0, 0, 13, 0, 0, 1);  check("dispatch13", State, 13);
      step(0, 0, 1, 0, 0, 1);   check("dispatch1", State, 1);
      // Wrap-around
      step(0, 2, 0, 127, 0, 1); check("jump127", State, 127);
      step(0, 1, 0, 0, 0, 1);   check("inc_wrap", State, 0);
      // Branch-if and branch-if-not
      step(0, 2, 0, 11, 0, 1);  step(0, 3, 0, 40, 1, 1); check("br_taken", State, 40);
      step(0, 2, 0, 11, 0, 1);  step(0, 3, 0, 40, 0, 1); check("br_not", State, 12);
      step(0, 2, 0, 11, 0, 1);  step(0, 5, 0, 40, 1, 1); check("brn_c1", State, 12);
      step(0, 2, 0, 11, 0, 1);  step(0, 5, 0, 40, 0, 1); check("brn_c0", State, 40);
      // Wait with three stalled cycles, then zero-wait
      step(0, 2, 0, 14, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 4, 0, 0, 0, 0);  check("wait_hold", State, 14);
      end
      step(0, 4, 0, 0, 0, 1);   check("wait_done", State, 15);
      step(0, 2, 0, 14, 0, 1);
      step(0, 4, 0, 0, 0, 1);   check("zero_wait", State, 15);
      // Illegal modes
      step(0, 6, 5, 9, 1, 1);   check("illegal6", State, 1);
      step(0, 2, 0, 50, 0, 1);
      step(0, 7, 5, 9, 1, 1);   check("illegal7", State, 1);
      // Reset mid-wait
      step(0, 2, 0, 14, 0, 1);
      step(0, 4, 0, 0, 0, 0);
      step(1, 4, 0, 0, 0, 0);   check("rst_in_wait", State, 0);

`ifdef SEQ_MOC_TIMEOUT_EN
      step(0, 2, 0, 20, 0, 1);
      for (int i = 0; i < TO; i++) step(0, 4, 0, 0, 0, 0);
      check("to_fault", State, 127);
      check("to_err", {31'd0, Timeout_Err}, 1);
      step(0, 1, 0, 0, 0, 1);   step(0, 2, 0, 30, 0, 1);
      check("to_sticky", {31'd0, Timeout_Err}, 1);
      step(1, 0, 0, 0, 0, 1);   check("to_clear", {31'd0, Timeout_Err}, 0);
      step(0, 2, 0, 20, 0, 1);
      for (int i = 0; i < TO - 1; i++) step(0, 4, 0, 0, 0, 0);
      step(0, 4, 0, 0, 0, 1);
      check("to_moc_wins", State, 21);
      check("to_moc_noerr", {31'd0, Timeout_Err}, 0);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(49) == 0), int'($urandom_range(7)), int'($urandom_range(127)),
              int'($urandom_range(127)), 1'($urandom_range(1)), ($urandom_range(9) < 7));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
